turbo_enc_ctrl: RTL and testbench
=================================

Name: turbo_enc_ctrl

Overview:
- Frame-level sequencer for the rate-1/3 turbo encoder.
- Buffers one frame of systematic bits into an internal bit array, then drives the two constituent convolutional encoders in lockstep:
  - encoder 1 gets natural order;
  - encoder 2 gets block-interleaved order (written row-wise, read column-wise).
- Owns the encoder enables, so each frame starts from encoder state 0.
- Emits frame handshakes and the systematic stream aligned to encoder symbol periods.

Parameters:
- ROWS, 5, interleaver rows.
- COLS, 8, interleaver columns.
- FRAME_LEN, ROWS*COLS (40), bits per frame; fixed by ROWS and COLS, never overridden independently.
- AW, 6, address width; must satisfy 2^AW >= FRAME_LEN.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  frame request; sampled only in IDLE.
- in_valid  in  1  input bit valid.
- in_bit  in  1  systematic input bit.
- in_ready  out  1  high only in LOAD; a write occurs when in_valid & in_ready.
- conv1_en  out  1  enable for encoder 1 (natural order).
- conv2_en  out  1  enable for encoder 2 (interleaved order).
- x1  out  1  encoder-1 input bit.
- x2  out  1  encoder-2 input bit.
- sys_bit  out  1  systematic bit for the current symbol (equals x1).
- sym_strobe  out  1  pulses on the second cycle of each 2-cycle symbol period.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset (async, while rst=1), all outputs 0:
  - state=IDLE; wr_cnt, k, r, c, ph all 0;
  - conv1_en=conv2_en=0, x1=x2=0, in_ready=0, done=0, sym_strobe=0.
  - Bit array contents are don't-care.
  - rst mid-frame aborts immediately. Encoders drop to state 0 because their enables fall.
- States: IDLE -> LOAD -> PRIME -> ENCODE -> DONE -> IDLE.
- IDLE:
  - start=1 -> LOAD, wr_cnt=0.
  - in_valid is ignored in IDLE, including in the same cycle as start.
- LOAD:
  - in_ready=1. On each in_valid: mem[wr_cnt]=in_bit, wr_cnt++.
  - The write with wr_cnt==FRAME_LEN-1 -> PRIME, and in_ready drops the next cycle.
  - Gaps in in_valid stall LOAD indefinitely.
- PRIME (1 cycle):
  - registers x1=mem[0], x2=mem[0] (interleaved index 0 is 0);
  - sets k=0, r=0, c=0, ph=0.
- ENCODE:
  - conv1_en=conv2_en=1 for exactly 2*FRAME_LEN cycles. ph toggles every cycle, starting at 0.
  - x1 and x2 are held constant across each ph=0/ph=1 pair, matching the encoders' two-cycle output serialisation.
  - sym_strobe = (ph==1).
  - On each ph==1 edge: k++, and x1 and x2 are registered for the next symbol:
    - x1 = mem[k+1];
    - x2 = mem[r'*COLS + c'], with (r',c') the successor of (r,c).
  - Interleaver successor:
    - r increments first;
    - at r==ROWS-1, r wraps to 0 and c increments;
    - read order is column-wise, il_addr = r*COLS + c.
  - At k==FRAME_LEN-1 with ph==1 -> DONE. Out-of-range addresses are never read.
- DONE (1 cycle):
  - done=1, conv1_en=conv2_en=0 (encoder reset gap), x1=x2=0;
  - -> IDLE next cycle.
- Timing:
  - start in IDLE to first in_ready: 1 cycle.
  - Last LOAD write to conv_en high: 2 cycles (through PRIME).
- start asserted while busy: ignored, not queued.
- Back-to-back frames: earliest next start is sampled in the IDLE cycle after DONE. Encoder enables are always low for at least 2 cycles between frames (DONE and IDLE).
- Address arithmetic:
  - r*COLS+c is computed in AW bits, no overflow for legal parameters;
  - k is AW bits and compared against FRAME_LEN-1.

Test Plan:
- Reset: rst pulse at arbitrary time -> all outputs 0 asynchronously; IDLE, busy=0.
- Small-config ordering, ROWS=2 COLS=3: load 1,0,0,1,1,0 -> across six symbols:
  - x1 sequence 1,0,0,1,1,0;
  - x2 sequence mem[0,3,1,4,2,5] = 1,1,0,1,0,0;
  - each value held 2 cycles, sym_strobe on the 2nd.
- Default frame, all-ones input of 40 bits:
  - conv1_en high exactly 80 cycles, sym_strobe count 40;
  - done pulse once, 1 cycle after the last strobe;
  - busy falls the cycle after done.
- LOAD with in_valid gaps (every 3rd cycle): 40 writes accepted, no extras. in_ready=0 from the cycle after the 40th write.
- start pulsed during LOAD and ENCODE -> no effect. start together with in_valid in IDLE -> that bit is not written; first write is the next in_valid.
- rst asserted at symbol 17 of ENCODE -> enables drop immediately. New frame after reset encodes correctly, identical to a fresh-frame golden model.

Source files
------------

// File: rtl/turbo_enc_ctrl.sv
// Frame sequencer for a rate-1/3 turbo encoder: buffers one frame of systematic
// bits, then feeds both constituent encoders (natural and block-interleaved order).
module turbo_enc_ctrl #(
    parameter int ROWS      = 5,
    parameter int COLS      = 8,
    parameter int FRAME_LEN = ROWS * COLS,
    parameter int AW        = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic in_valid,
    input  logic in_bit,
    output logic in_ready,
    output logic conv1_en,
    output logic conv2_en,
    output logic x1,
    output logic x2,
    output logic sys_bit,
    output logic sym_strobe,
    output logic busy,
    output logic done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);
    localparam logic [AW-1:0] ROW_LAST = AW'(ROWS - 1);
    localparam logic [AW-1:0] COLS_A   = AW'(COLS);

    typedef enum logic [2:0] {IDLE, LOAD, PRIME, ENCODE, DONE} state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   wr_cnt_reg, wr_cnt_next;
    logic [AW-1:0]   k_reg, k_next;
    logic [AW-1:0]   r_reg, r_next;
    logic [AW-1:0]   c_reg, c_next;
    logic            ph_reg, ph_next;
    logic            x1_reg, x1_next;
    logic            x2_reg, x2_next;

    logic [AW-1:0]   r_succ, c_succ, il_addr, nat_addr;
    logic            mem_we;

    // Frame buffer; contents need no reset since every frame rewrites all entries.
    logic            mem [FRAME_LEN];

    assign mem_we = (state_reg == LOAD) && in_valid;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_cnt_reg] <= in_bit;
        end
    end

    // Column-wise interleaver walk: row index advances first.
    always_comb begin
        if (r_reg == ROW_LAST) begin
            r_succ = '0;
            c_succ = c_reg + AW'(1);
        end else begin
            r_succ = r_reg + AW'(1);
            c_succ = c_reg;
        end
        il_addr  = r_succ * COLS_A + c_succ;
        nat_addr = k_reg + AW'(1);
    end

    always_comb begin
        state_next  = state_reg;
        wr_cnt_next = wr_cnt_reg;
        k_next      = k_reg;
        r_next      = r_reg;
        c_next      = c_reg;
        ph_next     = ph_reg;
        x1_next     = x1_reg;
        x2_next     = x2_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next  = LOAD;
                    wr_cnt_next = '0;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    wr_cnt_next = wr_cnt_reg + AW'(1);
                    if (wr_cnt_reg == LAST_IDX) begin
                        state_next = PRIME;
                    end
                end
            end
            PRIME: begin
                x1_next    = mem[0];
                x2_next    = mem[0];
                k_next     = '0;
                r_next     = '0;
                c_next     = '0;
                ph_next    = 1'b0;
                state_next = ENCODE;
            end
            ENCODE: begin
                ph_next = ~ph_reg;
                if (ph_reg) begin
                    // Last symbol: never fetch past the frame, clear the encoder inputs.
                    if (k_reg == LAST_IDX) begin
                        state_next = DONE;
                        x1_next    = 1'b0;
                        x2_next    = 1'b0;
                    end else begin
                        k_next  = nat_addr;
                        r_next  = r_succ;
                        c_next  = c_succ;
                        x1_next = mem[nat_addr];
                        x2_next = mem[il_addr];
                    end
                end
            end
            DONE: begin
                x1_next    = 1'b0;
                x2_next    = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            wr_cnt_reg <= '0;
            k_reg      <= '0;
            r_reg      <= '0;
            c_reg      <= '0;
            ph_reg     <= 1'b0;
            x1_reg     <= 1'b0;
            x2_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            wr_cnt_reg <= wr_cnt_next;
            k_reg      <= k_next;
            r_reg      <= r_next;
            c_reg      <= c_next;
            ph_reg     <= ph_next;
            x1_reg     <= x1_next;
            x2_reg     <= x2_next;
        end
    end

    assign in_ready   = (state_reg == LOAD);
    assign conv1_en   = (state_reg == ENCODE);
    assign conv2_en   = (state_reg == ENCODE);
    assign sym_strobe = (state_reg == ENCODE) && ph_reg;
    assign busy       = (state_reg != IDLE);
    assign done       = (state_reg == DONE);
    assign x1         = x1_reg;
    assign x2         = x2_reg;
    assign sys_bit    = x1_reg;

endmodule

// File: tb/tb_turbo_enc_ctrl.sv
// Directed bench for turbo_enc_ctrl: a default 5x8 instance and a small 2x3 instance,
// with expected encoder input streams queued at load time and popped per symbol.
module tb_turbo_enc_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic in_bit = 1'b0;
    logic sel = 1'b0;

    logic d_start, d_in_ready, d_c1, d_c2, d_x1, d_x2, d_sys, d_strobe, d_busy, d_done;
    logic s_start, s_in_ready, s_c1, s_c2, s_x1, s_x2, s_sys, s_strobe, s_busy, s_done;
    logic o_in_ready, o_c1, o_c2, o_x1, o_x2, o_sys, o_strobe, o_busy, o_done;

    int checks = 0;
    int errors = 0;
    logic bits [64];
    logic q1 [$];
    logic q2 [$];

    always #5 clk = ~clk;

    assign d_start = start & ~sel;
    assign s_start = start & sel;

    assign o_in_ready = sel ? s_in_ready : d_in_ready;
    assign o_c1       = sel ? s_c1       : d_c1;
    assign o_c2       = sel ? s_c2       : d_c2;
    assign o_x1       = sel ? s_x1       : d_x1;
    assign o_x2       = sel ? s_x2       : d_x2;
    assign o_sys      = sel ? s_sys      : d_sys;
    assign o_strobe   = sel ? s_strobe   : d_strobe;
    assign o_busy     = sel ? s_busy     : d_busy;
    assign o_done     = sel ? s_done     : d_done;

    turbo_enc_ctrl dut_d (
        .clk(clk), .rst(rst), .start(d_start), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(d_in_ready), .conv1_en(d_c1), .conv2_en(d_c2), .x1(d_x1), .x2(d_x2),
        .sys_bit(d_sys), .sym_strobe(d_strobe), .busy(d_busy), .done(d_done)
    );

    turbo_enc_ctrl #(.ROWS(2), .COLS(3), .AW(3)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(s_in_ready), .conv1_en(s_c1), .conv2_en(s_c2), .x1(s_x1), .x2(s_x2),
        .sys_bit(s_sys), .sym_strobe(s_strobe), .busy(s_busy), .done(s_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_d"}, {d_in_ready, d_c1, d_c2, d_x1, d_x2, d_sys, d_strobe, d_busy, d_done}, 0);
        check({tag, "_s"}, {s_in_ready, s_c1, s_c2, s_x1, s_x2, s_sys, s_strobe, s_busy, s_done}, 0);
    endtask

    // Natural order for encoder 1; column-wise read of the row-wise written block for encoder 2.
    task automatic push_expected(input int rows, input int cols);
        q1.delete();
        q2.delete();
        for (int k = 0; k < rows * cols; k++) q1.push_back(bits[k]);
        for (int c = 0; c < cols; c++)
            for (int r = 0; r < rows; r++) q2.push_back(bits[r * cols + c]);
    endtask

    // Pulses start with a stray in_valid bit (opposite of the first real bit) in IDLE.
    task automatic start_frame();
        start    = 1'b1;
        in_valid = 1'b1;
        in_bit   = ~bits[0];
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        check("in_ready_after_start", o_in_ready, 1);
        check("busy_after_start", o_busy, 1);
    endtask

    task automatic load_frame(input int n, input int gap);
        int writes = 0;
        int cyc = 0;
        while (writes < n && cyc < 8 * n) begin
            check("in_ready_load", o_in_ready, 1);
            in_valid = (cyc % gap == 0);
            in_bit   = bits[writes];
            start    = (cyc == 1);
            if (in_valid) writes++;
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check("load_completed", writes, n);
        check("in_ready_prime", o_in_ready, 0);
        check("en_prime", {o_c1, o_c2}, 0);
        check("busy_prime", o_busy, 1);
    endtask

    // Starts at the PRIME negedge; abort_sym >= 0 asserts rst at that symbol.
    task automatic encode_frame(input int n, input int abort_sym);
        for (int cyc = 0; cyc < 2 * n; cyc++) begin
            @(negedge clk);
            start = (cyc == 6);
            check("conv_en", {o_c1, o_c2}, 2'b11);
            check("sym_strobe", o_strobe, cyc % 2);
            if (q1.size() == 0 || q2.size() == 0) begin
                check("queue_underflow", 1, 0);
            end else begin
                check($sformatf("x1_sym%0d", cyc / 2), o_x1, q1[0]);
                check($sformatf("x2_sym%0d", cyc / 2), o_x2, q2[0]);
                check("sys_bit", o_sys, q1[0]);
                if (cyc % 2 == 1) begin
                    void'(q1.pop_front());
                    void'(q2.pop_front());
                end
            end
            if (abort_sym >= 0 && cyc == 2 * abort_sym) begin
                start = 1'b0;
                rst = 1'b1;
                #1;
                check_all_zero("abort_reset");
                @(negedge clk);
                rst = 1'b0;
                q1.delete();
                q2.delete();
                return;
            end
        end
        start = 1'b0;
        @(negedge clk);
        check("done_pulse", o_done, 1);
        check("en_done", {o_c1, o_c2}, 0);
        check("x_done", {o_x1, o_x2}, 0);
        check("busy_done", o_busy, 1);
        check("queue_drained", q1.size() + q2.size(), 0);
        @(negedge clk);
        check("done_cleared", o_done, 0);
        check("busy_idle", o_busy, 0);
        check("en_idle", {o_c1, o_c2}, 0);
    endtask

    initial begin
        #1;
        check_all_zero("reset_t0");
        repeat (2) @(negedge clk);
        check_all_zero("reset_held");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("idle_after_reset");

        // Small 2x3 block: known ordering.
        sel = 1'b1;
        bits[0] = 1; bits[1] = 0; bits[2] = 0; bits[3] = 1; bits[4] = 1; bits[5] = 0;
        push_expected(2, 3);
        start_frame();
        load_frame(6, 1);
        encode_frame(6, -1);

        // Default frame, all ones; next start issued in the IDLE cycle right after DONE.
        sel = 1'b0;
        for (int i = 0; i < 40; i++) bits[i] = 1'b1;
        push_expected(5, 8);
        start_frame();
        load_frame(40, 1);
        encode_frame(40, -1);

        // Random frame loaded with in_valid on every 3rd cycle.
        for (int i = 0; i < 40; i++) bits[i] = 1'($urandom_range(0, 1));
        push_expected(5, 8);
        start_frame();
        load_frame(40, 3);
        encode_frame(40, -1);

        // Abort at symbol 17, then a fresh frame must encode cleanly.
        for (int i = 0; i < 40; i++) bits[i] = 1'($urandom_range(0, 1));
        push_expected(5, 8);
        start_frame();
        load_frame(40, 1);
        encode_frame(40, 17);
        @(negedge clk);
        check("idle_after_abort", o_busy, 0);
        for (int i = 0; i < 40; i++) bits[i] = 1'($urandom_range(0, 1));
        push_expected(5, 8);
        start_frame();
        load_frame(40, 2);
        encode_frame(40, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
